// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the ID-stage datapath and the hazard controller.
// The master side drives the ID instruction and redirect; the slave side returns enables and counters.
interface hazard_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] id_inst_i;
  logic                  id_valid_i;
  logic                  ex_br_sel_i;
  logic                  pc_en_o;
  logic                  if_id_en_o;
  logic                  if_id_flush_o;
  logic                  id_ex_en_o;
  logic                  id_ex_bubble_o;
  logic [CNT_WIDTH-1:0]  stall_cnt_o;
  logic [CNT_WIDTH-1:0]  flush_cnt_o;

  modport master (
    output id_inst_i, id_valid_i, ex_br_sel_i,
    input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_bubble_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_inst_i, id_valid_i, ex_br_sel_i,
    output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_bubble_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Interlocking hazard controller for a 5-stage RISC-V pipeline without register-file write-through.
// A 3-deep rd scoreboard (EX, MEM, WB) drives stall/flush decisions; stalls and flushes are counted.
module hazard_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  hazard_ctrl_if.slave   bus
);

  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  logic [4:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       writesRd;
  logic       usesRs1;
  logic       usesRs2;
  logic       hazard;
  logic       stall;
  logic       flush;
  logic       issueValid;
  logic       unusedInst;

  // Scoreboard index 0 = EX, 1 = MEM, 2 = WB.
  logic [2:0]      sbValid_q, sbValid_d;
  logic [2:0][4:0] sbRd_q, sbRd_d;
  logic [CNT_WIDTH-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_WIDTH-1:0] flushCnt_q, flushCnt_d;

  assign opcode = bus.id_inst_i[6:2];
  assign rd     = bus.id_inst_i[11:7];
  assign rs1    = bus.id_inst_i[19:15];
  assign rs2    = bus.id_inst_i[24:20];
  assign unusedInst = ^{bus.id_inst_i[DATA_WIDTH-1:25], bus.id_inst_i[14:12], bus.id_inst_i[1:0]};

  always_comb begin
    writesRd = 1'b0;
    usesRs1  = 1'b0;
    usesRs2  = 1'b0;
    case (opcode)
      OP_OP:     begin writesRd = 1'b1; usesRs1 = 1'b1; usesRs2 = 1'b1; end
      OP_IMM:    begin writesRd = 1'b1; usesRs1 = 1'b1; end
      OP_LOAD:   begin writesRd = 1'b1; usesRs1 = 1'b1; end
      OP_LUI:    writesRd = 1'b1;
      OP_AUIPC:  writesRd = 1'b1;
      OP_JAL:    writesRd = 1'b1;
      OP_JALR:   begin writesRd = 1'b1; usesRs1 = 1'b1; end
      OP_STORE:  begin usesRs1 = 1'b1; usesRs2 = 1'b1; end
      OP_BRANCH: begin usesRs1 = 1'b1; usesRs2 = 1'b1; end
      default:   ;
    endcase
  end

  // Any in-flight producer of a live source register blocks ID until it retires past WB.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (sbValid_q[i] &&
          ((usesRs1 && (rs1 != 5'd0) && (sbRd_q[i] == rs1)) ||
           (usesRs2 && (rs2 != 5'd0) && (sbRd_q[i] == rs2)))) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard && bus.id_valid_i;
  end

  assign flush      = bus.ex_br_sel_i;
  assign stall      = hazard && !bus.ex_br_sel_i;
  assign issueValid = bus.id_valid_i && writesRd && (rd != 5'd0) && !stall && !flush;

  always_comb begin
    bus.pc_en_o        = 1'b1;
    bus.if_id_en_o     = 1'b1;
    bus.if_id_flush_o  = 1'b0;
    bus.id_ex_en_o     = 1'b1;
    bus.id_ex_bubble_o = 1'b0;
    if (flush) begin
      bus.if_id_flush_o  = 1'b1;
      bus.id_ex_bubble_o = 1'b1;
    end else if (stall) begin
      bus.pc_en_o        = 1'b0;
      bus.if_id_en_o     = 1'b0;
      bus.id_ex_bubble_o = 1'b1;
    end
  end

  // The scoreboard shifts every cycle; flush only blocks the new entry, older ones stay tracked.
  always_comb begin
    sbValid_d  = {sbValid_q[1:0], issueValid};
    sbRd_d     = {sbRd_q[1:0], rd};
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (stall && (stallCnt_q != {CNT_WIDTH{1'b1}})) begin
      stallCnt_d = stallCnt_q + CNT_WIDTH'(1);
    end
    if (flush && (flushCnt_q != {CNT_WIDTH{1'b1}})) begin
      flushCnt_d = flushCnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sbValid_q  <= '0;
      sbRd_q     <= '0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      sbValid_q  <= sbValid_d;
      sbRd_q     <= sbRd_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign bus.stall_cnt_o = stallCnt_q;
  assign bus.flush_cnt_o = flushCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a 16-bit-counter instance for function and a 4-bit-counter
// twin sharing the same inputs so counter saturation is reachable in a short run.
module tb_hazard_ctrl;

  typedef enum int {NORMAL, STALL, FLUSH} mode_e;

  localparam logic [31:0] ADDI_X5_X0_1 = 32'h00100293;
  localparam logic [31:0] ADD_X6_X5_X5 = 32'h00528333;
  localparam logic [31:0] ADDI_X0_X0_1 = 32'h00100013;
  localparam logic [31:0] ADD_X6_X0_X0 = 32'h00000333;
  localparam logic [31:0] LW_X7_0_X1   = 32'h0000A383;
  localparam logic [31:0] SW_X7_0_X2   = 32'h00712023;
  localparam logic [31:0] LUI_X7_1     = 32'h000013B7;
  localparam logic [31:0] ADDI_X9_X7_0 = 32'h00038493;
  localparam logic [31:0] LUI_X8_1     = 32'h00001437;
  localparam logic [31:0] LUI_X10_2    = 32'h00002537;
  localparam logic [31:0] JAL_X1_0     = 32'h000000EF;
  localparam logic [31:0] ADDI_X9_X1_0 = 32'h00008493;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   compared   = 0;
  int   mismatched = 0;

  hazard_ctrl_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) ifMain ();
  hazard_ctrl_if #(.DATA_WIDTH(32), .CNT_WIDTH(4))  ifSmall ();

  hazard_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (ifMain)
  );

  hazard_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dutSmall (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (ifSmall)
  );

  assign ifSmall.id_inst_i   = ifMain.id_inst_i;
  assign ifSmall.id_valid_i  = ifMain.id_valid_i;
  assign ifSmall.ex_br_sel_i = ifMain.ex_br_sel_i;

  always #5 clk_i = ~clk_i;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input mode_e mode,
                             input int expStall, input int expFlush);
    checkVal({tag, ".pc_en"},     32'(ifMain.pc_en_o),        32'(mode != STALL));
    checkVal({tag, ".if_id_en"},  32'(ifMain.if_id_en_o),     32'(mode != STALL));
    checkVal({tag, ".if_id_fl"},  32'(ifMain.if_id_flush_o),  32'(mode == FLUSH));
    checkVal({tag, ".id_ex_en"},  32'(ifMain.id_ex_en_o),     32'd1);
    checkVal({tag, ".bubble"},    32'(ifMain.id_ex_bubble_o), 32'(mode != NORMAL));
    checkVal({tag, ".stall_cnt"}, 32'(ifMain.stall_cnt_o),    32'(expStall));
    checkVal({tag, ".flush_cnt"}, 32'(ifMain.flush_cnt_o),    32'(expFlush));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic [31:0] inst, input logic valid, input logic br);
    @(negedge clk_i);
    ifMain.id_inst_i   = inst;
    ifMain.id_valid_i  = valid;
    ifMain.ex_br_sel_i = br;
    #1;
  endtask

  task automatic idle(input string tag, input int n, input int expStall, input int expFlush);
    for (int i = 0; i < n; i++) begin
      applyStimulus(32'h0, 1'b0, 1'b0);
      checkOutput(tag, NORMAL, expStall, expFlush);
    end
  endtask

  task automatic dependentPair(input string tag, input int startStall, input int expFlush);
    applyStimulus(ADDI_X5_X0_1, 1'b1, 1'b0);
    checkOutput({tag, ".prod"}, NORMAL, startStall, expFlush);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ADD_X6_X5_X5, 1'b1, 1'b0);
      checkOutput({tag, ".stall"}, STALL, startStall + i, expFlush);
    end
    applyStimulus(ADD_X6_X5_X5, 1'b1, 1'b0);
    checkOutput({tag, ".issue"}, NORMAL, startStall + 3, expFlush);
  endtask

  initial begin
    rst_ni             = 1'b0;
    ifMain.id_inst_i   = 32'h0;
    ifMain.id_valid_i  = 1'b0;
    ifMain.ex_br_sel_i = 1'b0;
    #6;
    checkOutput("reset", NORMAL, 0, 0);
    #1 rst_ni = 1'b1;

    dependentPair("dep", 0, 0);
    idle("idle1", 3, 3, 0);

    applyStimulus(ADDI_X0_X0_1, 1'b1, 1'b0);
    checkOutput("x0.prod", NORMAL, 3, 0);
    applyStimulus(ADD_X6_X0_X0, 1'b1, 1'b0);
    checkOutput("x0.cons", NORMAL, 3, 0);
    idle("idle2", 3, 3, 0);

    applyStimulus(LW_X7_0_X1, 1'b1, 1'b0);
    checkOutput("lw", NORMAL, 3, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(SW_X7_0_X2, 1'b1, 1'b0);
      checkOutput("sw.stall", STALL, 3 + i, 0);
    end
    applyStimulus(SW_X7_0_X2, 1'b1, 1'b0);
    checkOutput("sw.issue", NORMAL, 6, 0);
    idle("idle3", 3, 6, 0);

    applyStimulus(LUI_X7_1, 1'b1, 1'b0);
    checkOutput("lui7", NORMAL, 6, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ADDI_X9_X7_0, 1'b1, 1'b0);
      checkOutput("lui7.stall", STALL, 6 + i, 0);
    end
    applyStimulus(ADDI_X9_X7_0, 1'b1, 1'b0);
    checkOutput("lui7.issue", NORMAL, 9, 0);
    idle("idle4", 3, 9, 0);

    applyStimulus(LUI_X8_1, 1'b1, 1'b0);
    checkOutput("lui8", NORMAL, 9, 0);
    applyStimulus(LUI_X10_2, 1'b1, 1'b0);
    checkOutput("lui10", NORMAL, 9, 0);
    idle("idle5", 3, 9, 0);

    applyStimulus(ADDI_X5_X0_1, 1'b1, 1'b0);
    checkOutput("redir.prod", NORMAL, 9, 0);
    applyStimulus(ADD_X6_X5_X5, 1'b1, 1'b1);
    checkOutput("redir.flush", FLUSH, 9, 0);
    idle("redir.after", 3, 9, 1);

    applyStimulus(JAL_X1_0, 1'b1, 1'b0);
    checkOutput("jal", NORMAL, 9, 1);
    applyStimulus(ADDI_X9_X1_0, 1'b1, 1'b1);
    checkOutput("jal.flush", FLUSH, 9, 1);
    applyStimulus(ADDI_X9_X1_0, 1'b1, 1'b0);
    checkOutput("jal.keep1", STALL, 9, 2);
    applyStimulus(ADDI_X9_X1_0, 1'b1, 1'b0);
    checkOutput("jal.keep2", STALL, 10, 2);
    applyStimulus(ADDI_X9_X1_0, 1'b1, 1'b0);
    checkOutput("jal.issue", NORMAL, 11, 2);
    idle("idle6", 3, 11, 2);

    dependentPair("sat1", 11, 2);
    idle("idle7", 3, 14, 2);
    dependentPair("sat2", 14, 2);
    checkVal("small.stall_sat", 32'(ifSmall.stall_cnt_o), 32'h0000000F);
    checkVal("small.flush_cnt", 32'(ifSmall.flush_cnt_o), 32'd2);
    idle("idle8", 3, 17, 2);
    dependentPair("sat3", 17, 2);
    checkVal("small.stall_hold", 32'(ifSmall.stall_cnt_o), 32'h0000000F);
    idle("idle9", 3, 20, 2);

    applyStimulus(ADDI_X5_X0_1, 1'b1, 1'b0);
    checkOutput("rst.prod", NORMAL, 20, 2);
    applyStimulus(ADD_X6_X5_X5, 1'b1, 1'b0);
    checkOutput("rst.stall", STALL, 20, 2);
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("rst.async", NORMAL, 0, 0);
    checkVal("small.rst_cnt", 32'(ifSmall.stall_cnt_o), 32'd0);
    @(posedge clk_i);
    #2;
    checkOutput("rst.held", NORMAL, 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkOutput("rst.release", NORMAL, 0, 0);
    @(posedge clk_i);
    #1;
    checkOutput("rst.issue", NORMAL, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
